// File: rtl/div_iter_unit.sv
// -----------------------------------------------------------------------------
// div_iter_unit
//   Iterative radix-2 restoring divider for the EX stage (MIPS DIV / DIVU).
//   One operation is accepted per start pulse while idle. stallreq is held high
//   from the issuing cycle until the last iteration so the pipeline freezes
//   around the divide. Quotient/remainder are delivered with a HI/LO
//   write-enable pair that can drive the hilo register file directly.
//
// Parameters
//   WIDTH         operand/result width (>= 4); one quotient bit per cycle
//
// Ports
//   clk           clock, all state on rising edge
//   rst           asynchronous active-low reset
//   start         request a new divide (only honoured in IDLE)
//   signed_op     1 = DIV (two's complement), 0 = DIVU
//   annul         flush: cancels an in-flight op, wins over start
//   dividend      numerator, sampled on an accepted start
//   divisor       denominator, sampled on an accepted start
//   stallreq      pipeline stall request
//   result_valid  one-cycle pulse, quotient/remainder valid
//   quotient      LO value
//   remainder     HI value
//   hilo_we       {hi_we, lo_we}, 2'b11 together with result_valid
//   div_zero      (DIV_ZERO_TRAP_EN only) pulses with result_valid when the
//                 divisor was zero
//
// Build option
//   DIV_ZERO_TRAP_EN  adds div_zero and finishes zero-divisor operations one
//                     cycle after acceptance instead of iterating.
// -----------------------------------------------------------------------------
module div_iter_unit #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             signed_op,
    input  logic             annul,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             stallreq,
    output logic             result_valid,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
`ifdef DIV_ZERO_TRAP_EN
    output logic             div_zero,
`endif
    output logic [1:0]       hilo_we
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_DIV  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   a_q, a_d;          // dividend magnitude, shifts out MSB first / quotient shifts in
    logic [WIDTH-1:0]   b_q, b_d;          // divisor magnitude
    logic [WIDTH-1:0]   rem_q, rem_d;      // partial remainder (always < divisor, so WIDTH bits hold it)
    logic               q_neg_q, q_neg_d;
    logic               r_neg_q, r_neg_d;
    logic               b_zero_q, b_zero_d;
    logic               valid_q, valid_d;
    logic [WIDTH-1:0]   quot_q, quot_d;
    logic [WIDTH-1:0]   remo_q, remo_d;
`ifdef DIV_ZERO_TRAP_EN
    logic               dz_q, dz_d;
`endif

    logic               dvd_neg, dvs_neg;
    logic [WIDTH-1:0]   dvd_mag, dvs_mag;
    logic [WIDTH:0]     rem_shift;         // WIDTH+1-bit shifted partial remainder
    logic               sub_ok;
    logic [WIDTH-1:0]   diff;
    logic               last_iter;
    logic               finish;

    assign dvd_neg   = signed_op & dividend[WIDTH-1];
    assign dvs_neg   = signed_op & divisor[WIDTH-1];
    assign dvd_mag   = dvd_neg ? -dividend : dividend;
    assign dvs_mag   = dvs_neg ? -divisor : divisor;

    assign rem_shift = {rem_q, a_q[WIDTH-1]};
    assign sub_ok    = (rem_shift >= {1'b0, b_q});
    // The true difference is below the divisor, so the low WIDTH bits are exact.
    assign diff      = rem_shift[WIDTH-1:0] - b_q;
    assign last_iter = (cnt_q == CNT_W'(WIDTH - 1));

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        a_d      = a_q;
        b_d      = b_q;
        rem_d    = rem_q;
        q_neg_d  = q_neg_q;
        r_neg_d  = r_neg_q;
        b_zero_d = b_zero_q;
        valid_d  = 1'b0;
        quot_d   = quot_q;
        remo_d   = remo_q;
        finish   = 1'b0;
`ifdef DIV_ZERO_TRAP_EN
        dz_d     = 1'b0;
`endif

        case (state_q)
            S_IDLE: begin
                if (start && !annul) begin
                    a_d      = dvd_mag;
                    b_d      = dvs_mag;
                    rem_d    = '0;
                    q_neg_d  = dvd_neg ^ dvs_neg;
                    r_neg_d  = dvd_neg;
                    b_zero_d = (divisor == '0);
                    cnt_d    = '0;
                    state_d  = S_DIV;
`ifdef DIV_ZERO_TRAP_EN
                    // Short-cut: preload what the iterations would have produced.
                    if (divisor == '0) begin
                        a_d     = '1;
                        rem_d   = dvd_mag;
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end
`endif
                end
            end

            S_DIV: begin
                if (annul) begin
                    state_d = S_IDLE;
                end else begin
                    rem_d = sub_ok ? diff : rem_shift[WIDTH-1:0];
                    a_d   = {a_q[WIDTH-2:0], sub_ok};
                    cnt_d = cnt_q + CNT_W'(1);
                    if (last_iter) begin
                        state_d = S_DONE;
                        finish  = 1'b1;
                    end
                end
            end

            S_DONE: begin
                state_d = S_IDLE;
            end

            default: begin
                state_d = S_IDLE;
            end
        endcase

        // Results are registered on the edge that enters DONE, so they are
        // computed from the next-state magnitudes and signs.
        if (finish) begin
            valid_d = 1'b1;
            // Zero divisor always reports all ones regardless of operand signs.
            quot_d  = b_zero_d ? '1 : (q_neg_d ? -a_d : a_d);
            remo_d  = r_neg_d ? -rem_d : rem_d;
`ifdef DIV_ZERO_TRAP_EN
            dz_d    = b_zero_d;
`endif
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            rem_q    <= '0;
            q_neg_q  <= 1'b0;
            r_neg_q  <= 1'b0;
            b_zero_q <= 1'b0;
            valid_q  <= 1'b0;
            quot_q   <= '0;
            remo_q   <= '0;
`ifdef DIV_ZERO_TRAP_EN
            dz_q     <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            a_q      <= a_d;
            b_q      <= b_d;
            rem_q    <= rem_d;
            q_neg_q  <= q_neg_d;
            r_neg_q  <= r_neg_d;
            b_zero_q <= b_zero_d;
            valid_q  <= valid_d;
            quot_q   <= quot_d;
            remo_q   <= remo_d;
`ifdef DIV_ZERO_TRAP_EN
            dz_q     <= dz_d;
`endif
        end
    end

    // Combinational so the issuing cycle already stalls; forced low in reset.
    assign stallreq     = rst & (((state_q == S_IDLE) & start & ~annul) | (state_q == S_DIV));
    // A flush during DONE suppresses the write-back.
    assign result_valid = valid_q & ~annul;
    assign hilo_we      = {2{result_valid}};
    assign quotient     = quot_q;
    assign remainder    = remo_q;
`ifdef DIV_ZERO_TRAP_EN
    assign div_zero     = dz_q & ~annul;
`endif

endmodule

// File: tb/tb_div_iter_unit.sv
module tb_div_iter_unit;

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        logic        dz;
        int          cyc;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst;
    logic        start, signed_op, annul;
    logic [31:0] dividend, divisor;
    logic        stallreq, result_valid;
    logic [31:0] quotient, remainder;
    logic [1:0]  hilo_we;
    logic        div_zero;

    logic        start8, signed_op8, annul8;
    logic [7:0]  dividend8, divisor8;
    logic        stallreq8, result_valid8;
    logic [7:0]  quotient8, remainder8;
    logic [1:0]  hilo_we8;
    logic        div_zero8;

    int   cyc = 0;
    int   n_checks = 0;
    int   n_pass = 0;
    int   n_txn = 0;
    exp_t exp_q[$];
    exp_t exp8_q[$];
    exp_t me, me8;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    div_iter_unit #(.WIDTH(32)) u_dut (
        .clk(clk), .rst(rst), .start(start), .signed_op(signed_op), .annul(annul),
        .dividend(dividend), .divisor(divisor), .stallreq(stallreq),
        .result_valid(result_valid), .quotient(quotient), .remainder(remainder),
`ifdef DIV_ZERO_TRAP_EN
        .div_zero(div_zero),
`endif
        .hilo_we(hilo_we)
    );

    div_iter_unit #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst(rst), .start(start8), .signed_op(signed_op8), .annul(annul8),
        .dividend(dividend8), .divisor(divisor8), .stallreq(stallreq8),
        .result_valid(result_valid8), .quotient(quotient8), .remainder(remainder8),
`ifdef DIV_ZERO_TRAP_EN
        .div_zero(div_zero8),
`endif
        .hilo_we(hilo_we8)
    );

`ifndef DIV_ZERO_TRAP_EN
    assign div_zero  = 1'b0;
    assign div_zero8 = 1'b0;
`endif

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] expv);
        n_checks++;
        if (act === expv) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h at cycle %0d", nm, act, expv, cyc);
    endtask

    function automatic int lat_for(input int w, input logic [31:0] b);
        int l;
        l = w;
`ifdef DIV_ZERO_TRAP_EN
        if (b == 32'd0) l = 0;
`endif
        return l;
    endfunction

    // Monitor / scoreboard for the 32-bit unit.
    always @(negedge clk) begin
        if (rst === 1'b1 && result_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid: got result_valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                me = exp_q.pop_front();
                n_txn++;
                $display("txn %0d w32: q=0x%08h r=0x%08h cycle=%0d", n_txn, quotient, remainder, cyc);
                check("quotient", 64'(quotient), 64'(me.q));
                check("remainder", 64'(remainder), 64'(me.r));
                check("hilo_we", 64'(hilo_we), 64'(2'b11));
                check("latency", 64'(cyc), 64'(me.cyc));
`ifdef DIV_ZERO_TRAP_EN
                check("div_zero", 64'(div_zero), 64'(me.dz));
`endif
            end
        end
    end

    // Monitor / scoreboard for the 8-bit unit.
    always @(negedge clk) begin
        if (rst === 1'b1 && result_valid8 === 1'b1) begin
            if (exp8_q.size() == 0) begin
                n_checks++;
                $display("FAIL unexpected_valid8: got result_valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                me8 = exp8_q.pop_front();
                n_txn++;
                $display("txn %0d w8: q=0x%02h r=0x%02h cycle=%0d", n_txn, quotient8, remainder8, cyc);
                check("quotient8", 64'(quotient8), 64'(me8.q[7:0]));
                check("remainder8", 64'(remainder8), 64'(me8.r[7:0]));
                check("latency8", 64'(cyc), 64'(me8.cyc));
`ifdef DIV_ZERO_TRAP_EN
                check("div_zero8", 64'(div_zero8), 64'(me8.dz));
`endif
            end
        end
    end

    // Called at a negedge; returns at the negedge of the IDLE cycle after DONE.
    task automatic run_op(input logic sg, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] eq, input logic [31:0] er, input int hold);
        exp_t e;
        int   acc;
        int   lat;
        signed_op = sg; dividend = a; divisor = b; start = 1'b1;
        #1;
        check("stall_issue", 64'(stallreq), 64'(1));
        @(posedge clk); #1;
        acc = cyc;
        lat = lat_for(32, b);
        e.q = eq; e.r = er; e.dz = (b == 32'd0); e.cyc = acc + lat;
        exp_q.push_back(e);
        // Scramble operands to show they were latched on the accept edge.
        dividend = ~a; divisor = a ^ b;
        for (int i = 0; i < hold; i++) begin
            @(posedge clk); #1;
        end
        start = 1'b0;
        @(negedge clk);
        if (lat > 0) check("stall_busy", 64'(stallreq), 64'(1));
        while (cyc < acc + lat) @(negedge clk);
        check("stall_done", 64'(stallreq), 64'(0));
        @(negedge clk);
    endtask

    task automatic run8(input logic sg, input logic [7:0] a, input logic [7:0] b);
        exp_t e;
        int   sa, sb, acc;
        if (b == 8'd0) begin
            e.q = 32'hFF; e.r = {24'd0, a};
        end else if (sg) begin
            sa = $signed(a); sb = $signed(b);
            e.q = {24'd0, 8'(sa / sb)}; e.r = {24'd0, 8'(sa % sb)};
        end else begin
            e.q = {24'd0, a / b}; e.r = {24'd0, a % b};
        end
        signed_op8 = sg; dividend8 = a; divisor8 = b; start8 = 1'b1;
        @(posedge clk); #1;
        acc = cyc;
        e.dz = (b == 8'd0);
        e.cyc = acc + lat_for(8, {24'd0, b});
        exp8_q.push_back(e);
        start8 = 1'b0; dividend8 = ~a;
        @(negedge clk);
        while (cyc < e.cyc) @(negedge clk);
        @(negedge clk);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int acc;
        logic [7:0] av[9];
        logic [7:0] bv[8];
        av = '{8'd0, 8'd1, 8'd7, 8'd100, 8'd127, 8'd128, 8'd129, 8'd200, 8'd255};
        bv = '{8'd0, 8'd1, 8'd2, 8'd3, 8'd7, 8'd127, 8'd128, 8'd255};

        rst = 1'b0; start = 1'b0; signed_op = 1'b0; annul = 1'b0;
        dividend = '0; divisor = '0;
        start8 = 1'b0; signed_op8 = 1'b0; annul8 = 1'b0; dividend8 = '0; divisor8 = '0;
        @(negedge clk); @(negedge clk);
        check("rst_stallreq", 64'(stallreq), 64'(0));
        check("rst_valid", 64'(result_valid), 64'(0));
        check("rst_quotient", 64'(quotient), 64'(0));
        check("rst_remainder", 64'(remainder), 64'(0));
        check("rst_hilo_we", 64'(hilo_we), 64'(0));
        rst = 1'b1;
        @(negedge clk);

        // Basic unsigned, signed sign rules, overflow, zero divisor.
        run_op(1'b0, 32'd100, 32'd7, 32'd14, 32'd2, 0);
        run_op(1'b1, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFD, 32'hFFFFFFFF, 0);
        run_op(1'b1, 32'd7, 32'hFFFFFFFE, 32'hFFFFFFFD, 32'd1, 0);
        run_op(1'b1, 32'hFFFFFF9C, 32'hFFFFFFF9, 32'd14, 32'hFFFFFFFE, 0);
        run_op(1'b1, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 32'd0, 0);
        run_op(1'b0, 32'd5, 32'd0, 32'hFFFFFFFF, 32'd5, 0);
        run_op(1'b1, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFF, 32'hFFFFFFFB, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'h10, 32'h0FFFFFFF, 32'hF, 0);
        run_op(1'b0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'd1, 32'd0, 0);
        // start held high while busy must not queue a second op.
        run_op(1'b0, 32'd1000, 32'd3, 32'd333, 32'd1, 5);

        // annul together with start in IDLE: nothing accepted.
        start = 1'b1; annul = 1'b1; dividend = 32'd9; divisor = 32'd3;
        #1;
        check("annul_idle_stall", 64'(stallreq), 64'(0));
        @(posedge clk); #1;
        start = 1'b0; annul = 1'b0;
        #1;
        check("annul_idle_state", 64'(stallreq), 64'(0));
        @(negedge clk);

        // annul in cycle 10 of an op.
        start = 1'b1; signed_op = 1'b0; dividend = 32'd77; divisor = 32'd5;
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
        while (cyc < acc + 9) @(negedge clk);
        check("annul_pre_stall", 64'(stallreq), 64'(1));
        annul = 1'b1;
        @(posedge clk); #1;
        annul = 1'b0;
        check("annul_post_stall", 64'(stallreq), 64'(0));
        check("annul_post_valid", 64'(result_valid), 64'(0));
        @(negedge clk);
        run_op(1'b0, 32'd77, 32'd5, 32'd15, 32'd2, 0);

        // Reset mid-operation.
        start = 1'b1; signed_op = 1'b0; dividend = 32'h12345678; divisor = 32'h10;
        @(posedge clk); #1;
        start = 1'b0;
        acc = cyc;
        exp_q.push_back('{q: 32'h01234567, r: 32'h8, dz: 1'b0, cyc: acc + 32});
        while (cyc < acc + 14) @(negedge clk);
        rst = 1'b0;
        #1;
        check("rst_mid_stallreq", 64'(stallreq), 64'(0));
        check("rst_mid_valid", 64'(result_valid), 64'(0));
        check("rst_mid_quotient", 64'(quotient), 64'(0));
        check("rst_mid_remainder", 64'(remainder), 64'(0));
        check("rst_mid_hilo_we", 64'(hilo_we), 64'(0));
        exp_q.delete();
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        run_op(1'b0, 32'h12345678, 32'h10, 32'h01234567, 32'h8, 0);

        // 8-bit sweep against an arithmetic model.
        for (int s = 0; s < 2; s++)
            for (int i = 0; i < 9; i++)
                for (int j = 0; j < 8; j++)
                    run8(s[0], av[i], bv[j]);

        repeat (3) @(negedge clk);
        check("pending32", 64'(exp_q.size()), 64'(0));
        check("pending8", 64'(exp8_q.size()), 64'(0));
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
